// File: rtl/alpha_gain_ctrl.sv
// alpha_gain_ctrl: multi-level gain selector for the HDR sample path.
// Steps the gain level up at once on overload. Steps it down one level after
// a masked run of consecutive quiet samples. A short hold-off after every
// level change keeps quiet counting paused while the analog front end settles.
module alpha_gain_ctrl #(
  parameter int DATA_W          = 9,
  parameter int NUM_LEVELS      = 4,
  parameter int TO_W            = 5,
  parameter int HOLDOFF_SAMPLES = 2,
  localparam int LVL_W          = $clog2(NUM_LEVELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_sampling,
  input  logic [DATA_W-1:0] hdr_current_value,
  input  logic [DATA_W-1:0] threshold_high,
  input  logic [DATA_W-1:0] threshold_low,
  input  logic [TO_W-1:0]   timeout_mask,
  output logic [LVL_W-1:0]  alpha,
  output logic              alpha_up,
  output logic              alpha_down
);

  localparam int HO_W = (HOLDOFF_SAMPLES < 2) ? 1 : $clog2(HOLDOFF_SAMPLES + 1);
  localparam logic [HO_W-1:0] HO_LAST =
    HO_W'((HOLDOFF_SAMPLES > 0) ? (HOLDOFF_SAMPLES - 1) : 0);
  localparam logic [LVL_W-1:0] ALPHA_MAX = LVL_W'(NUM_LEVELS - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAG_SAT  = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic {
    TRACK,
    HOLDOFF
  } state_t;

  state_t            state_q, state_d;
  logic [LVL_W-1:0]  alpha_q, alpha_d;
  logic              alpha_up_q, alpha_up_d;
  logic              alpha_down_q, alpha_down_d;
  logic [TO_W-1:0]   quiet_cnt_q, quiet_cnt_d;
  logic [HO_W-1:0]   holdoff_cnt_q, holdoff_cnt_d;

  logic [DATA_W-1:0] mag;
  logic              over;
  logic              quiet;
  logic [TO_W-1:0]   quiet_cnt_inc;

  // Sample magnitude; the most negative code saturates so it stays representable.
  always_comb begin
    mag = hdr_current_value;
    if (hdr_current_value == MOST_NEG) begin
      mag = MAG_SAT;
    end else if (hdr_current_value[DATA_W-1]) begin
      mag = ~hdr_current_value + 1'b1;
    end
    over          = mag > threshold_high;
    quiet         = mag < threshold_low;
    quiet_cnt_inc = (&quiet_cnt_q) ? quiet_cnt_q : quiet_cnt_q + 1'b1;
  end

  // Next-state logic: hold-off progression, then step-up / step-down priority.
  always_comb begin
    state_d       = state_q;
    alpha_d       = alpha_q;
    alpha_up_d    = 1'b0;
    alpha_down_d  = 1'b0;
    quiet_cnt_d   = quiet_cnt_q;
    holdoff_cnt_d = holdoff_cnt_q;

    if (enable_sampling) begin
      if (state_q == HOLDOFF) begin
        if (holdoff_cnt_q == HO_LAST) begin
          state_d       = TRACK;
          holdoff_cnt_d = '0;
        end else begin
          holdoff_cnt_d = holdoff_cnt_q + 1'b1;
        end
      end

      if (over) begin
        quiet_cnt_d = '0;
        if (alpha_q != ALPHA_MAX) begin
          alpha_d    = alpha_q + 1'b1;
          alpha_up_d = 1'b1;
          if (HOLDOFF_SAMPLES > 0) begin
            state_d       = HOLDOFF;
            holdoff_cnt_d = '0;
          end
        end
      end else if (quiet && (state_q == TRACK) && (alpha_q != '0) &&
                   (timeout_mask != '0)) begin
        if ((quiet_cnt_inc & timeout_mask) == timeout_mask) begin
          alpha_d      = alpha_q - 1'b1;
          alpha_down_d = 1'b1;
          quiet_cnt_d  = '0;
          if (HOLDOFF_SAMPLES > 0) begin
            state_d       = HOLDOFF;
            holdoff_cnt_d = '0;
          end
        end else begin
          quiet_cnt_d = quiet_cnt_inc;
        end
      end else begin
        quiet_cnt_d = '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= TRACK;
      alpha_q       <= '0;
      alpha_up_q    <= 1'b0;
      alpha_down_q  <= 1'b0;
      quiet_cnt_q   <= '0;
      holdoff_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      alpha_q       <= alpha_d;
      alpha_up_q    <= alpha_up_d;
      alpha_down_q  <= alpha_down_d;
      quiet_cnt_q   <= quiet_cnt_d;
      holdoff_cnt_q <= holdoff_cnt_d;
    end
  end

  assign alpha      = alpha_q;
  assign alpha_up   = alpha_up_q;
  assign alpha_down = alpha_down_q;

endmodule

// File: tb/tb_alpha_gain_ctrl.sv
// tb_alpha_gain_ctrl: directed self-checking bench for alpha_gain_ctrl
// with default parameters (9-bit samples, 4 levels, 5-bit mask, 2-sample hold-off).
module tb_alpha_gain_ctrl;

  logic       clk;
  logic       reset;
  logic       enable_sampling;
  logic [8:0] hdr_current_value;
  logic [8:0] threshold_high;
  logic [8:0] threshold_low;
  logic [4:0] timeout_mask;
  logic [1:0] alpha;
  logic       alpha_up;
  logic       alpha_down;

  int checks;
  int failures;

  alpha_gain_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .enable_sampling   (enable_sampling),
    .hdr_current_value (hdr_current_value),
    .threshold_high    (threshold_high),
    .threshold_low     (threshold_low),
    .timeout_mask      (timeout_mask),
    .alpha             (alpha),
    .alpha_up          (alpha_up),
    .alpha_down        (alpha_down)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One enabled sample; outputs are looked at 1 ns after the sampling edge.
  task automatic strobe(input int v);
    @(negedge clk);
    hdr_current_value = 9'(v);
    enable_sampling   = 1'b1;
    @(posedge clk);
    #1;
    enable_sampling   = 1'b0;
  endtask

  task automatic set_defaults();
    threshold_high  = 9'd200;
    threshold_low   = 9'd50;
    timeout_mask    = 5'b10000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset           = 1'b0;
    enable_sampling = 1'b0;
    set_defaults();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reset held low while overloading strobes keep arriving.
  task automatic test_reset();
    reset           = 1'b0;
    enable_sampling = 1'b0;
    hdr_current_value = 9'(300);
    set_defaults();
    for (int i = 0; i < 6; i++) begin
      strobe(300);
      checks++;
      if ({alpha, alpha_up, alpha_down} !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_hold[%0d] got alpha=%0d up=%b down=%b want 0/0/0",
                 i, alpha, alpha_up, alpha_down);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Strobe every 8 clocks: alpha moves only on the strobe edge, pulse lasts one clock.
  task automatic test_gating_step_up();
    do_reset();
    for (int lvl = 1; lvl <= 3; lvl++) begin
      strobe(210);
      checks++;
      if ({alpha, alpha_up, alpha_down} !== {2'(lvl), 2'b10}) begin
        failures++;
        $display("[TB] FAIL step_up[%0d] got alpha=%0d up=%b down=%b want %0d/1/0",
                 lvl, alpha, alpha_up, alpha_down, lvl);
      end
      for (int k = 0; k < 7; k++) begin
        @(posedge clk);
        #1;
        checks++;
        if ({alpha, alpha_up, alpha_down} !== {2'(lvl), 2'b00}) begin
          failures++;
          $display("[TB] FAIL gated_idle[%0d.%0d] got alpha=%0d up=%b down=%b want %0d/0/0",
                   lvl, k, alpha, alpha_up, alpha_down, lvl);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      strobe(210);
      checks++;
      if ({alpha, alpha_up, alpha_down} !== 4'b1100) begin
        failures++;
        $display("[TB] FAIL saturate[%0d] got alpha=%0d up=%b down=%b want 3/0/0",
                 i, alpha, alpha_up, alpha_down);
      end
    end
  endtask

  // Negative samples: -205 and saturated -256 step up, -12 is quiet and counted.
  task automatic test_negative();
    do_reset();
    strobe(-205);
    checks++;
    if ({alpha, alpha_up} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL neg205 got alpha=%0d up=%b want 1/1", alpha, alpha_up);
    end
    threshold_high = 9'd255;
    strobe(-256);
    checks++;
    if ({alpha, alpha_up} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL neg256_eq_th got alpha=%0d up=%b want 1/0", alpha, alpha_up);
    end
    threshold_high = 9'd254;
    strobe(-256);
    checks++;
    if ({alpha, alpha_up} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL neg256_over got alpha=%0d up=%b want 2/1", alpha, alpha_up);
    end
    threshold_high = 9'd200;
    for (int s = 1; s <= 18; s++) begin
      strobe(-12);
      checks++;
      if ({alpha, alpha_down} !== ((s == 18) ? 3'b011 : 3'b100)) begin
        failures++;
        $display("[TB] FAIL neg12_quiet[%0d] got alpha=%0d down=%b want %0d/%0d",
                 s, alpha, alpha_down, (s == 18) ? 1 : 2, (s == 18) ? 1 : 0);
      end
    end
  endtask

  // From alpha=3 just after a step-up: down on the 18th quiet strobe, twice.
  task automatic test_step_down();
    do_reset();
    repeat (3) strobe(210);
    for (int lvl = 3; lvl >= 2; lvl--) begin
      for (int s = 1; s <= 18; s++) begin
        strobe(40);
        checks++;
        if ({alpha, alpha_up, alpha_down} !==
            ((s == 18) ? {2'(lvl - 1), 2'b01} : {2'(lvl), 2'b00})) begin
          failures++;
          $display("[TB] FAIL step_down[%0d.%0d] got alpha=%0d up=%b down=%b",
                   lvl, s, alpha, alpha_up, alpha_down);
        end
      end
    end
  endtask

  // Quiet runs broken by a non-quiet sample (including mag==threshold_low) never time out.
  task automatic test_counter_reset();
    do_reset();
    strobe(210);
    repeat (2) strobe(40);
    for (int pass = 0; pass < 2; pass++) begin
      repeat (15) strobe(40);
      strobe((pass == 0) ? 70 : 50);
      checks++;
      if ({alpha, alpha_down} !== 3'b010) begin
        failures++;
        $display("[TB] FAIL break_run[%0d] got alpha=%0d down=%b want 1/0", pass, alpha, alpha_down);
      end
    end
    for (int s = 1; s <= 16; s++) begin
      strobe(40);
      checks++;
      if ({alpha, alpha_down} !== ((s == 16) ? 3'b001 : 3'b010)) begin
        failures++;
        $display("[TB] FAIL after_break[%0d] got alpha=%0d down=%b", s, alpha, alpha_down);
      end
    end
    // Disabled step-down
    do_reset();
    strobe(210);
    timeout_mask = 5'b00000;
    for (int s = 1; s <= 40; s++) begin
      strobe(40);
      checks++;
      if ({alpha, alpha_down} !== 3'b010) begin
        failures++;
        $display("[TB] FAIL mask_zero[%0d] got alpha=%0d down=%b want 1/0", s, alpha, alpha_down);
      end
    end
    // Mask changed mid-count applies to the existing count
    do_reset();
    strobe(210);
    repeat (5) strobe(40);
    checks++;
    if ({alpha, alpha_down} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL mask_pre got alpha=%0d down=%b want 1/0", alpha, alpha_down);
    end
    timeout_mask = 5'b00100;
    strobe(40);
    checks++;
    if ({alpha, alpha_down} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL mask_change got alpha=%0d down=%b want 0/1", alpha, alpha_down);
    end
  endtask

  // Threshold edges and the inverted-threshold case.
  task automatic test_boundaries();
    do_reset();
    strobe(200);
    checks++;
    if ({alpha, alpha_up} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL mag_eq_high got alpha=%0d up=%b want 0/0", alpha, alpha_up);
    end
    strobe(201);
    checks++;
    if ({alpha, alpha_up} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL mag_above_high got alpha=%0d up=%b want 1/1", alpha, alpha_up);
    end
    threshold_low = 9'd250;
    strobe(210);
    checks++;
    if ({alpha, alpha_up, alpha_down} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL over_wins got alpha=%0d up=%b down=%b want 2/1/0",
               alpha, alpha_up, alpha_down);
    end
  endtask

  // Step-up during hold-off happens at once and restarts the hold-off.
  task automatic test_back_to_back();
    do_reset();
    strobe(210);
    strobe(210);
    checks++;
    if ({alpha, alpha_up} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL second_up got alpha=%0d up=%b want 2/1", alpha, alpha_up);
    end
    for (int s = 1; s <= 18; s++) begin
      strobe(40);
      checks++;
      if ({alpha, alpha_down} !== ((s == 18) ? 3'b011 : 3'b100)) begin
        failures++;
        $display("[TB] FAIL holdoff_restart[%0d] got alpha=%0d down=%b", s, alpha, alpha_down);
      end
    end
  endtask

  // Reset asserted mid-count clears outputs without waiting for a clock.
  task automatic test_async_reset();
    do_reset();
    strobe(210);
    strobe(210);
    repeat (5) strobe(40);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({alpha, alpha_up, alpha_down} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset got alpha=%0d up=%b down=%b want 0/0/0",
               alpha, alpha_up, alpha_down);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b0;
    enable_sampling   = 1'b0;
    hdr_current_value = '0;
    set_defaults();
    $display("[TB] start");
    test_reset();
    test_gating_step_up();
    test_negative();
    test_step_down();
    test_counter_reset();
    test_boundaries();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
